// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants for the 4-word multiply sequence stream
// Contents: word/operand widths, group length, multiplier and shift constants,
// and the checker state encodings. The generator reuses the same constants.
package mul_seq_pkg;

  localparam int WORD_W    = 11;  // stream word width
  localparam int OP_W      = 8;   // operand width
  localparam int GROUP_LEN = 4;   // operand, x3, x7, <<3
  localparam int MUL_A     = 3;
  localparam int MUL_B     = 7;
  localparam int SHIFT_C   = 3;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;  // waiting for a grant
  localparam logic [ST_W-1:0] ST_W3   = 2'd1;  // expecting op*3
  localparam logic [ST_W-1:0] ST_W7   = 2'd2;  // expecting op*7
  localparam logic [ST_W-1:0] ST_W8   = 2'd3;  // expecting op<<3

endpackage

// File: rtl/mul_seq_expect.sv
// rtl/mul_seq_expect.sv - expected product word for the current checker state
// Ports:
//   state    in  ST_W    checker state
//   op       in  OP_W    captured operand
//   exp_word out WORD_W  expected word (zero-extended product; 0 in IDLE)
module mul_seq_expect
  import mul_seq_pkg::*;
(
  input  logic [ST_W-1:0]   state,
  input  logic [OP_W-1:0]   op,
  output logic [WORD_W-1:0] exp_word
);

  // Widen before multiplying so op*7 and op<<3 keep their top bits.
  logic [WORD_W-1:0] op_ext;
  assign op_ext = WORD_W'(op);

  always_comb begin
    exp_word = '0;
    case (state)
      ST_W3:   exp_word = op_ext * WORD_W'(MUL_A);
      ST_W7:   exp_word = op_ext * WORD_W'(MUL_B);
      ST_W8:   exp_word = op_ext << SHIFT_C;
      default: exp_word = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq_checker.sv
// rtl/mul_seq_checker.sv - receive-side checker for the operand/x3/x7/<<3 stream
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-low reset
//   grant_in  in   1       group start, high on the operand word
//   data_in   in   WORD_W  stream word
//   valid     out  1       one-cycle pulse, a complete group was checked
//   op_out    out  OP_W    recovered operand, held between groups
//   err       out  1       with valid: the group had a mismatching word
//   sync_err  out  1       one-cycle pulse, group aborted by an early grant
//   err_cnt   out  CNT_W   saturating count of bad or aborted groups
module mul_seq_checker
  import mul_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              valid,
  output logic [OP_W-1:0]   op_out,
  output logic              err,
  output logic              sync_err,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [ST_W-1:0]   state;
  logic [OP_W-1:0]   op;
  logic              acc_err;
  logic [WORD_W-1:0] exp_word;
  logic              mismatch;
  logic              cnt_full;

  mul_seq_expect u_expect (
    .state    (state),
    .op       (op),
    .exp_word (exp_word)
  );

  assign mismatch = (data_in != exp_word);
  assign cnt_full = (err_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op       <= '0;
      acc_err  <= 1'b0;
      valid    <= 1'b0;
      op_out   <= '0;
      err      <= 1'b0;
      sync_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
      if (grant_in) begin
        // A grant always starts a new group; outside IDLE it also kills the
        // partial one, which counts as a bad group.
        if (state != ST_IDLE) begin
          sync_err <= 1'b1;
          if (!cnt_full) err_cnt <= err_cnt + CNT_W'(1);
        end
        op      <= data_in[OP_W-1:0];
        acc_err <= |data_in[WORD_W-1:OP_W];
        state   <= ST_W3;
      end else begin
        case (state)
          ST_W3: begin
            acc_err <= acc_err | mismatch;
            state   <= ST_W7;
          end
          ST_W7: begin
            acc_err <= acc_err | mismatch;
            state   <= ST_W8;
          end
          ST_W8: begin
            // Final compare folds straight into the reported result.
            valid   <= 1'b1;
            op_out  <= op;
            err     <= acc_err | mismatch;
            acc_err <= 1'b0;
            if ((acc_err | mismatch) && !cnt_full) err_cnt <= err_cnt + CNT_W'(1);
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_checker.sv
// tb/tb_mul_seq_checker.sv - scoreboard bench for mul_seq_checker
module tb_mul_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        grant_in = 1'b0;
  logic [10:0] data_in = '0;

  logic        valid, err, sync_err;
  logic [7:0]  op_out;
  logic [7:0]  err_cnt;
  logic        valid2, err2, sync_err2;
  logic [7:0]  op_out2;
  logic [1:0]  err_cnt2;

  mul_seq_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .grant_in(grant_in), .data_in(data_in),
    .valid(valid), .op_out(op_out), .err(err), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  mul_seq_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .grant_in(grant_in), .data_in(data_in),
    .valid(valid2), .op_out(op_out2), .err(err2), .sync_err(sync_err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] op;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   sync_cnt = 0;
  int   last_valid_cyc = -1;
  int   prev_valid_cyc = -1;
  int   last_sync_cyc = -1;
  int   last_word_cyc = 0;
  int   first_word_cyc = 0;

  always @(posedge clk) cyc++;

  // Output monitor: every valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: valid=1 op_out=%0d, required no pulse", op_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 2;
        if (op_out !== e.op) begin
          errors++;
          $display("FAIL sb_op_out: got %0d, required %0d", op_out, e.op);
        end
        if (err !== e.err) begin
          errors++;
          $display("FAIL sb_err: got %0b, required %0b (op %0d)", err, e.err, e.op);
        end
      end
    end
    if (sync_err) begin
      sync_cnt++;
      last_sync_cyc = cyc;
    end
  end

  task automatic send_word(input logic g, input logic [10:0] d);
    @(negedge clk);
    grant_in = g;
    data_in  = d;
  endtask

  // Sends a full group and queues its reference result.
  task automatic send_group(input logic [10:0] w0, input logic [10:0] w1,
                            input logic [10:0] w2, input logic [10:0] w3);
    exp_t        e;
    logic [10:0] o;
    o     = {3'b000, w0[7:0]};
    e.op  = w0[7:0];
    e.err = (w0[10:8] != 3'b000) || (w1 != o * 11'd3) || (w2 != o * 11'd7) || (w3 != o * 11'd8);
    sb.push_back(e);
    send_word(1'b1, w0);
    first_word_cyc = cyc + 1;
    send_word(1'b0, w1);
    send_word(1'b0, w2);
    send_word(1'b0, w3);
    last_word_cyc = cyc + 1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    send_word(1'b0, 11'd0);
    while (sb.size() != 0 && n < 20) begin
      send_word(1'b0, 11'd0);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    grant_in = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %0b, required 0", err); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %0b, required 0", sync_err); end
    if (op_out !== 8'd0)   begin errors++; $display("FAIL reset_op_out: got %0d, required 0", op_out); end
    if (err_cnt !== 8'd0)  begin errors++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
    if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_err_cnt2: got %0d, required 0", err_cnt2); end
  endtask

  task automatic test_basic();
    int v0;
    v0 = valid_cnt;
    send_group(11'd5, 11'd15, 11'd35, 11'd40);
    drain("basic");
    checks += 3;
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, required 1", valid_cnt - v0); end
    if (last_valid_cyc !== last_word_cyc) begin
      errors++; $display("FAIL basic_latency: valid at cycle %0d, required %0d", last_valid_cyc, last_word_cyc);
    end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d, required 0", err_cnt); end
  endtask

  task automatic test_limits();
    send_group(11'd255, 11'd765, 11'd1785, 11'd2040);
    drain("limits");
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL limits_err_cnt: got %0d, required 0", err_cnt); end
  endtask

  task automatic test_mismatch();
    do_reset();
    send_group(11'd10, 11'd30, 11'd69, 11'd80);
    drain("mismatch");
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL mismatch_err_cnt: got %0d, required 1", err_cnt); end
    send_group(11'h105, 11'd15, 11'd35, 11'd40);
    drain("high_bits");
    checks++;
    if (err_cnt !== 8'd2) begin errors++; $display("FAIL high_bits_err_cnt: got %0d, required 2", err_cnt); end
  endtask

  task automatic test_early_grant();
    int v0, s0;
    do_reset();
    v0 = valid_cnt;
    s0 = sync_cnt;
    send_word(1'b1, 11'd4);
    send_word(1'b0, 11'd12);
    send_group(11'd9, 11'd27, 11'd63, 11'd72);
    drain("early");
    checks += 4;
    if (sync_cnt - s0 !== 1) begin errors++; $display("FAIL early_sync_pulses: got %0d, required 1", sync_cnt - s0); end
    if (last_sync_cyc !== first_word_cyc) begin
      errors++; $display("FAIL early_sync_cycle: got %0d, required %0d", last_sync_cyc, first_word_cyc);
    end
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL early_valid_pulses: got %0d, required 1", valid_cnt - v0); end
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL early_err_cnt: got %0d, required 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = valid_cnt;
    send_group(11'd3, 11'd9, 11'd21, 11'd24);
    send_group(11'd6, 11'd18, 11'd42, 11'd48);
    drain("b2b");
    checks += 3;
    if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", valid_cnt - v0); end
    if (last_valid_cyc - prev_valid_cyc !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d, required 4", last_valid_cyc - prev_valid_cyc);
    end
    if (sync_cnt !== 0 && last_sync_cyc > first_word_cyc - 8) begin
      errors++; $display("FAIL b2b_sync: sync_err seen at cycle %0d, required none", last_sync_cyc);
    end
  endtask

  task automatic test_saturation();
    logic [10:0] o;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      o = 11'(i);
      send_group(o, o * 11'd3, o * 11'd7 + 11'd1, o * 11'd8);
    end
    drain("sat");
    checks += 2;
    if (err_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_err_cnt2: got %0d, required 3", err_cnt2); end
    if (err_cnt !== 8'd5)  begin errors++; $display("FAIL sat_err_cnt: got %0d, required 5", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int v0, s0;
    v0 = valid_cnt;
    s0 = sync_cnt;
    send_word(1'b1, 11'd1);
    send_word(1'b0, 11'd3);
    send_word(1'b0, 11'd7);
    @(negedge clk);
    rst = 1'b0;
    grant_in = 1'b1;
    data_in = 11'd8;
    #1;
    checks += 4;
    if (valid !== 1'b0)   begin errors++; $display("FAIL mid_valid: got %0b, required 0", valid); end
    if (op_out !== 8'd0)  begin errors++; $display("FAIL mid_op_out: got %0d, required 0", op_out); end
    if (err !== 1'b0)     begin errors++; $display("FAIL mid_err: got %0b, required 0", err); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err_cnt: got %0d, required 0", err_cnt); end
    repeat (2) @(negedge clk);
    grant_in = 1'b0;
    data_in = '0;
    rst = 1'b1;
    repeat (3) send_word(1'b0, 11'd8);
    checks += 2;
    if (valid_cnt !== v0) begin errors++; $display("FAIL mid_no_valid: got %0d pulses, required 0", valid_cnt - v0); end
    if (sync_cnt !== s0)  begin errors++; $display("FAIL mid_no_sync: got %0d pulses, required 0", sync_cnt - s0); end
    send_group(11'd1, 11'd3, 11'd7, 11'd8);
    drain("after_mid");
    checks += 2;
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_mid_pulses: got %0d, required 1", valid_cnt - v0); end
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL after_mid_err_cnt: got %0d, required 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_mismatch();
    test_early_grant();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
